rom_download_sdram: RTL

Consumes the byte-wide ROM download stream produced by the SPI data_io stage (ioctl_download / ioctl_wr / ioctl_addr / ioctl_dout / ioctl_index) and writes it into 16-bit external memory through a request/acknowledge port. It packs byte pairs into words with byte enables and decouples the bursty write stream from memory latency with a small FIFO. It holds the game core in reset during and shortly after a download, and reports completion, byte count and overflow.

---
 rtl/rom_download_sdram.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_download_sdram.sv
// rom_download_sdram: packs the byte-wide ROM download stream into 16-bit
// memory writes with byte enables, buffers them in a small FIFO and holds
// the game core in reset until the download has been fully written.
module rom_download_sdram #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_HOLD = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        core_reset,
  output logic        load_done,
  output logic [24:0] byte_count,
  output logic        overflow
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef struct packed {
    logic [23:0] waddr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  // Registered state
  logic [1:0]        state, state_nxt;
  logic              wr_q, dl_q;
  logic              hold_valid, hold_valid_nxt;
  logic [7:0]        hold_data, hold_data_nxt;
  logic [23:0]       hold_waddr, hold_waddr_nxt;
  logic              pend_valid, pend_valid_nxt;
  logic [7:0]        pend_data, pend_data_nxt;
  logic [23:0]       pend_waddr, pend_waddr_nxt;
  word_t             fifo_q [FIFO_DEPTH];
  word_t             fifo_q_nxt [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_vld, fifo_vld_nxt;
  logic [CNT_W-1:0]  fifo_cnt, fifo_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              core_reset_nxt, load_done_nxt, overflow_nxt;
  logic [24:0]       byte_count_nxt;

  // Combinational helpers
  logic              ev, dl_rise, dl_fall;
  logic [23:0]       ev_waddr;
  logic              push;
  word_t             push_word;
  logic              pop, full, push_ok, push_drop;
  logic [CNT_W-1:0]  wr_idx;
  logic              drained, enter_load;
  logic              unused_bits;

  // One event per byte: first cycle of the strobe while a download is active
  assign ev       = ioctl_wr && !wr_q && ioctl_download;
  assign dl_rise  = ioctl_download && !dl_q;
  assign dl_fall  = !ioctl_download && dl_q;
  assign ev_waddr = {ioctl_index[1:0], ioctl_addr[22:1]};
  assign unused_bits = ^{ioctl_index[7:2], ioctl_addr[24:23]};

  // FIFO head drives the memory port directly from registers
  assign mem_req  = fifo_vld[0];
  assign mem_addr = fifo_q[0].waddr;
  assign mem_din  = fifo_q[0].data;
  assign mem_be   = fifo_q[0].be;

  assign pop       = fifo_vld[0] && mem_ack;
  assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;
  assign drained   = (fifo_cnt == '0) && !hold_valid && !pend_valid && !push;

  // Byte pairing: hold register for even bytes, pending slot for a split odd byte
  always_comb begin
    push           = 1'b0;
    push_word      = '0;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    hold_waddr_nxt = hold_waddr;
    pend_valid_nxt = pend_valid;
    pend_data_nxt  = pend_data;
    pend_waddr_nxt = pend_waddr;

    if (pend_valid) begin
      push           = 1'b1;
      push_word      = '{waddr: pend_waddr, data: {pend_data, 8'h00}, be: 2'b10};
      pend_valid_nxt = 1'b0;
    end else if (ev) begin
      if (!ioctl_addr[0]) begin
        if (hold_valid) begin
          push      = 1'b1;
          push_word = '{waddr: hold_waddr, data: {8'h00, hold_data}, be: 2'b01};
        end
        hold_valid_nxt = 1'b1;
        hold_data_nxt  = ioctl_dout;
        hold_waddr_nxt = ev_waddr;
      end else if (hold_valid && (hold_waddr == ev_waddr)) begin
        push           = 1'b1;
        push_word      = '{waddr: ev_waddr, data: {ioctl_dout, hold_data}, be: 2'b11};
        hold_valid_nxt = 1'b0;
      end else if (!hold_valid) begin
        push      = 1'b1;
        push_word = '{waddr: ev_waddr, data: {ioctl_dout, 8'h00}, be: 2'b10};
      end else begin
        push           = 1'b1;
        push_word      = '{waddr: hold_waddr, data: {8'h00, hold_data}, be: 2'b01};
        hold_valid_nxt = 1'b0;
        pend_valid_nxt = 1'b1;
        pend_data_nxt  = ioctl_dout;
        pend_waddr_nxt = ev_waddr;
      end
    end else if ((state == ST_FLUSH) && hold_valid) begin
      push           = 1'b1;
      push_word      = '{waddr: hold_waddr, data: {8'h00, hold_data}, be: 2'b01};
      hold_valid_nxt = 1'b0;
    end
  end

  // Shift-register FIFO: entry 0 is always the head so the port stays registered
  always_comb begin
    fifo_q_nxt   = fifo_q;
    fifo_vld_nxt = fifo_vld;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        fifo_q_nxt[i]   = fifo_q[i+1];
        fifo_vld_nxt[i] = fifo_vld[i+1];
      end
      fifo_vld_nxt[FIFO_DEPTH-1] = 1'b0;
    end
    wr_idx = pop ? (fifo_cnt - CNT_W'(1)) : fifo_cnt;
    if (push_ok) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (CNT_W'(i) == wr_idx) begin
          fifo_q_nxt[i]   = push_word;
          fifo_vld_nxt[i] = 1'b1;
        end
      end
    end
    fifo_cnt_nxt = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // Download sequencing: next state and registered status outputs
  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    load_done_nxt  = load_done;
    byte_count_nxt = ev ? (byte_count + 25'd1) : byte_count;
    overflow_nxt   = overflow | push_drop;
    enter_load     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (dl_rise) enter_load = 1'b1;
      end
      ST_LOAD: begin
        if (dl_fall) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (drained) begin
          if (ioctl_download) begin
            enter_load = 1'b1;
          end else begin
            state_nxt    = ST_HOLD;
            hold_cnt_nxt = HOLD_W'(RESET_HOLD - 1);
          end
        end
      end
      ST_HOLD: begin
        if (dl_rise) begin
          enter_load = 1'b1;
        end else if (hold_cnt == '0) begin
          state_nxt     = ST_IDLE;
          load_done_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (enter_load) begin
      state_nxt      = ST_LOAD;
      load_done_nxt  = 1'b0;
      byte_count_nxt = ev ? 25'd1 : 25'd0;
      overflow_nxt   = push_drop;
    end

    core_reset_nxt = (state_nxt != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_IDLE;
      wr_q       <= 1'b0;
      dl_q       <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_waddr <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_waddr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
      fifo_vld   <= '0;
      fifo_cnt   <= '0;
      hold_cnt   <= '0;
      core_reset <= 1'b0;
      load_done  <= 1'b0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_q       <= ioctl_wr;
      dl_q       <= ioctl_download;
      hold_valid <= hold_valid_nxt;
      hold_data  <= hold_data_nxt;
      hold_waddr <= hold_waddr_nxt;
      pend_valid <= pend_valid_nxt;
      pend_data  <= pend_data_nxt;
      pend_waddr <= pend_waddr_nxt;
      fifo_q     <= fifo_q_nxt;
      fifo_vld   <= fifo_vld_nxt;
      fifo_cnt   <= fifo_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      core_reset <= core_reset_nxt;
      load_done  <= load_done_nxt;
      byte_count <= byte_count_nxt;
      overflow   <= overflow_nxt;
    end
  end

endmodule
